// File: rtl/exec_datapath.sv
// Single-issue datapath: register file, immediate extender, ALU and writeback mux
// sequenced by a FETCH/EXEC/WB FSM. Optional overflow trap: EXEC_OVF_TRAP_EN.
module exec_datapath #(
  parameter int unsigned DataSize = 32,
  parameter int unsigned AddrSize = 5,
  parameter int unsigned RegNum   = 2**AddrSize
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [AddrSize-1:0] read_address1,
  input  logic [AddrSize-1:0] read_address2,
  input  logic [AddrSize-1:0] write_address,
  input  logic [4:0]          imm_5bit,
  input  logic [14:0]         imm_15bit,
  input  logic [19:0]         imm_20bit,
  input  logic [1:0]          imm_sel,
  input  logic                imm_reg_select,
  input  logic                wb_select,
  input  logic                wb_en,
  input  logic [3:0]          opcode,
  output logic                result_valid,
  output logic [DataSize-1:0] result,
  output logic                alu_overflow,
  output logic                ovf_sticky
);

  localparam int unsigned ShiftW = $clog2(DataSize);
  localparam int unsigned Msb    = DataSize - 1;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

  state_t              state;
  logic [AddrSize-1:0] ra1_q, ra2_q, wa_q;
  logic [4:0]          imm5_q;
  logic [14:0]         imm15_q;
  logic [19:0]         imm20_q;
  logic [1:0]          imm_sel_q;
  logic                irs_q, wbs_q, wbe_q;
  logic [3:0]          opcode_q;
  logic [DataSize-1:0] src1_q, src2_q;
  logic [DataSize-1:0] regs [RegNum];

  logic [DataSize-1:0] imm_ext_c, alu_res_c, sum_c, diff_c;
  logic [ShiftW-1:0]   shamt_c;
  logic                alu_ovf_c, wr_en_c;

  // Immediate formats: zero or sign extension to the datapath width
  always_comb begin
    imm_ext_c = '0;
    case (imm_sel_q)
      2'b00:   imm_ext_c = DataSize'(imm5_q);
      2'b01:   imm_ext_c = DataSize'($signed(imm15_q));
      2'b10:   imm_ext_c = DataSize'(imm15_q);
      default: imm_ext_c = DataSize'($signed(imm20_q));
    endcase
  end

  assign sum_c   = src1_q + src2_q;
  assign diff_c  = src1_q - src2_q;
  assign shamt_c = src2_q[ShiftW-1:0];

  always_comb begin
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    case (opcode_q)
      4'h0: begin
        alu_res_c = sum_c;
        alu_ovf_c = (src1_q[Msb] == src2_q[Msb]) && (sum_c[Msb] != src1_q[Msb]);
      end
      4'h1: begin
        alu_res_c = diff_c;
        alu_ovf_c = (src1_q[Msb] != src2_q[Msb]) && (diff_c[Msb] != src1_q[Msb]);
      end
      4'h2:    alu_res_c = src1_q & src2_q;
      4'h3:    alu_res_c = src1_q | src2_q;
      4'h4:    alu_res_c = src1_q ^ src2_q;
      4'h5:    alu_res_c = src1_q << shamt_c;
      4'h6:    alu_res_c = src1_q >> shamt_c;
      4'h7:    alu_res_c = $unsigned($signed(src1_q) >>> shamt_c);
      4'h8:    alu_res_c = DataSize'($signed(src1_q) < $signed(src2_q));
      4'h9:    alu_res_c = src2_q;
      default: alu_res_c = '0;
    endcase
  end

`ifdef EXEC_OVF_TRAP_EN
  // An overflowing ALU writeback is dropped; forwarding src2 is never trapped
  assign wr_en_c = wbe_q && !(alu_overflow && !wbs_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (state == EXEC && alu_ovf_c) begin
      ovf_sticky <= 1'b1;
    end
  end
`else
  assign wr_en_c    = wbe_q;
  assign ovf_sticky = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      instr_ready  <= 1'b1;
      ra1_q        <= '0;
      ra2_q        <= '0;
      wa_q         <= '0;
      imm5_q       <= '0;
      imm15_q      <= '0;
      imm20_q      <= '0;
      imm_sel_q    <= '0;
      irs_q        <= 1'b0;
      wbs_q        <= 1'b0;
      wbe_q        <= 1'b0;
      opcode_q     <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      alu_overflow <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ra1_q       <= read_address1;
            ra2_q       <= read_address2;
            wa_q        <= write_address;
            imm5_q      <= imm_5bit;
            imm15_q     <= imm_15bit;
            imm20_q     <= imm_20bit;
            imm_sel_q   <= imm_sel;
            irs_q       <= imm_reg_select;
            wbs_q       <= wb_select;
            wbe_q       <= wb_en;
            opcode_q    <= opcode;
            instr_ready <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          src1_q <= regs[ra1_q];
          src2_q <= irs_q ? imm_ext_c : regs[ra2_q];
          state  <= EXEC;
        end
        EXEC: begin
          result       <= wbs_q ? src2_q : alu_res_c;
          alu_overflow <= alu_ovf_c;
          result_valid <= 1'b1;
          state        <= WB;
        end
        WB: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register file; the WB write lands before the next FETCH, so no forwarding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RegNum); i++) regs[i] <= '0;
    end else if (state == WB && wr_en_c) begin
      regs[wa_q] <= result;
    end
  end

endmodule

// File: doc/exec_datapath.md
Name: exec_datapath

Overview:
- Parametrised successor of the single-issue register-file/ALU datapath.
- Self-contained: register file, immediate extender with real zero/sign extension, ALU, writeback mux.
- Sequenced by an internal FETCH/EXEC/WB state machine behind a valid/ready instruction handshake.
- Sits between instruction decode and the core's result bus; decode presents one decoded instruction, then waits for ready.

Parameters:
- DataSize, 32, datapath width in bits; must be >= 20.
- AddrSize, 5, register address width.
- RegNum, 2**AddrSize, number of registers.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- instr_valid  input  1  decoded instruction present
- instr_ready  output  1  block can accept an instruction
- read_address1  input  AddrSize  src1 register
- read_address2  input  AddrSize  src2 register
- write_address  input  AddrSize  destination register
- imm_5bit  input  5  immediate field
- imm_15bit  input  15  immediate field
- imm_20bit  input  20  immediate field
- imm_sel  input  2  immediate format select
- imm_reg_select  input  1  1 = src2 is immediate, 0 = src2 is register
- wb_select  input  1  1 = write src2, 0 = write ALU result
- wb_en  input  1  write destination register
- opcode  input  4  ALU operation
- result_valid  output  1  one-cycle pulse, result presented
- result  output  DataSize  value written (or that would be written)
- alu_overflow  output  1  signed overflow of this instruction, valid with result_valid
- ovf_sticky  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (async, any state): FSM to IDLE; all registers 0; result, result_valid, alu_overflow, ovf_sticky cleared to 0; instr_ready = 1 once rst deasserts. An instruction in flight is discarded with no writeback.
- FSM states and transitions:
  - IDLE: instr_ready = 1. On instr_valid && instr_ready at a rising edge, latch all instruction inputs and go to FETCH.
  - FETCH: read both registers into operand registers; form the extended immediate; select src2. Go to EXEC.
  - EXEC: compute the ALU result and overflow into registers. Go to WB.
  - WB: result_valid = 1 for exactly this cycle; write the register if wb_en. Go to IDLE.
- Latency and throughput:
  - Accept edge at cycle N; result_valid high during cycle N+3. One instruction per 4 cycles.
  - instr_ready = 0 in FETCH, EXEC and WB.
  - Inputs are ignored outside the accept edge.
- Hazards: a WB write completes before the next FETCH, so back-to-back dependent instructions read the new value. No forwarding is needed.
- Immediate extension:
  - imm_sel 00: zero-extend imm_5bit.
  - imm_sel 01: sign-extend imm_15bit.
  - imm_sel 10: zero-extend imm_15bit.
  - imm_sel 11: sign-extend imm_20bit.
- ALU ops (src1 = register 1, src2 = selected operand; shift amount = src2[log2(DataSize)-1:0]):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA
  - 1000 SLT signed, result 1 or 0
  - 1001 PASS src2
  - All other codes: result 0.
- Overflow: alu_overflow = signed overflow for ADD/SUB only, otherwise 0. Results wrap modulo 2**DataSize.
- result = src2 when wb_select = 1, else ALU result. result holds its value after the valid pulse until the next WB.
- Register 0 is an ordinary register, not hardwired.
- Same-register cases: read_address1 == read_address2 == write_address reads the old value and writes the new one at WB.

Optional Feature:
- Macro: EXEC_OVF_TRAP_EN.
- Defined:
  - An ADD/SUB with overflow (wb_select = 0) suppresses the register write even if wb_en = 1.
  - ovf_sticky is set in the WB cycle and stays 1 until reset.
  - result_valid, result and alu_overflow behave as normal.
- Not defined: the write always occurs when wb_en = 1; ovf_sticky is tied to 0.

Test Plan:
- Reset, then write 5 to r1 (PASS, imm_sel 00, imm5 = 5, wb_en) -> result_valid exactly 3 cycles after the accept edge, result = 0x00000005; later read of r1 = 5.
- imm_sel 01, imm15 = 0x4000, PASS -> result 0xFFFFC000. imm_sel 10, same imm -> 0x00004000. imm_sel 11, imm20 = 0x80000 -> 0xFFF80000.
- r1 = 0x7FFFFFFF, ADD imm5 = 1 -> result 0x80000000, alu_overflow = 1. With EXEC_OVF_TRAP_EN: r1 unchanged and ovf_sticky = 1. Without it: r1 = 0x80000000 and ovf_sticky = 0.
- Dependent pair r2 = r1 + 1 then r3 = r2 + 1, with instr_valid held high -> second accept exactly 4 cycles after the first; r3 = r1 + 2.
- r1 = 0x80000000, SRA by 4 -> 0xF8000000; SRL by 4 -> 0x08000000; SLT r1 < 1 -> 1.
- Assert rst during EXEC of a write to r4 -> no result_valid pulse; r4 = 0; instr_ready = 1 in the first cycle after rst falls.
